id_stage_pipe: RTL and testbench
================================

// Module: id_stage_pipe
// PURPOSE
//  Parametrised instruction-decode stage of the pipelined core, sitting between the IF/ID and EX stages.
//  Decodes one 32-bit instruction per cycle and reads two operands from an internal register file.
//  Write-back writes are bypassed into same-cycle reads.
//  Decoded controls, operands and immediate are registered into the ID/EX pipeline register, with stall and flush handling.
// PARAMETERS
//  DATA_W          32  operand/PC/result width (>=32)
//  NREGS           16  architectural registers (8 or 16); index = low $clog2(NREGS) bits of 4-bit fields
//  PC_READ_OFFSET  8   value added to pc_if when register 15 is read (NREGS==16 only)
// PORTS
//  clk             in   1       clock, all state on rising edge
//  reset           in   1       asynchronous, active-high
//  valid_if        in   1       instr_if/pc_if valid
//  instr_if        in   32      instruction from IF/ID
//  pc_if           in   DATA_W  PC of instr_if
//  stall_i         in   1       hold ID/EX register contents
//  flush_i         in   1       load a bubble into ID/EX
//  regw_wb         in   1       write-back enable
//  rd_wb           in   4       write-back destination
//  result_wb       in   DATA_W  write-back data
//  valid_id        out  1       ID/EX entry valid
//  pc_id           out  DATA_W  registered PC
//  a_id, b_id      out  DATA_W  registered Rn / Rm operands
//  imm_id          out  DATA_W  registered extended immediate
//  rn_id,rm_id,rd_id out 4      registered register fields
//  regw_id,flagw_id,memw_id,memr_id,branch_id,imm_sel_id  out 1  registered controls
//  alu_ctrl_id     out  2       ALU command
//  cond_id         out  2       branch condition select
//  hazard_stall_o  out  1       load-use stall request to IF (combinational)
// BEHAVIOUR
//  Encoding: [31:30] op (00 DP, 01 MEM, 10 BR, 11 reserved), [29] I, [28:27] funct, [26] S/L, [19:16] Rn, [15:12] Rd, [3:0] Rm.
//  Immediates: DP/MEM imm = zero-extended [11:0]; BR imm = sign-extended [23:0] << 2.
//  DP: regw=1, flagw=S, alu_ctrl=funct, imm_sel=I.
//  MEM: imm_sel=1, alu_ctrl=00; L=1 -> memr=1, regw=1; L=0 -> memw=1, regw=0.
//  BR: branch=1, cond=funct, imm_sel=1.
//  Reserved op: all controls 0, valid_id=0.
//  Regfile: written on rising edge when regw_wb. Reads combinational. Same-cycle write to a read index returns result_wb.
//  R15 read returns pc_if+PC_OFFSET; writes to R15 are ignored.
//  ID/EX update priority per edge: reset > flush_i (bubble) > stall_i (hold) > hazard bubble > load decode.
//  Bubble: valid_id and all control bits 0; data fields don't-care, driven 0.
//  Latency: 1 cycle from instr_if to ID/EX outputs. valid_if=0 loads a bubble.
//  Reset (async, any time incl. mid-stall): every output and every regfile entry -> 0. hazard_stall_o=0 while reset.
// CONFIGURATION
//  ID_HAZARD_DETECT_EN defined: hazard_stall_o=1 when valid_id & memr_id & rd_id != 0xF & valid_if &
//   (rd_id==Rn of instr_if, or rd_id==Rm of instr_if when I=0). That cycle a bubble is loaded into ID/EX; IF holds.
//  Not defined: hazard_stall_o tied 0; no bubble insertion.
// STRUCTURE
//  Package id_pkg: op_t enum, field bit-position localparams, ctrl_t packed struct (regw..cond), BUBBLE_CTRL constant.
//  Sub-module id_regfile #(DATA_W,NREGS): async clear, 1 write port, 2 read ports, write-through bypass.
//  Top: decoder always_comb, immediate extender, hazard compare, ID/EX always_ff.
// TESTING
//  After reset, 0x20001004 (ADD imm, Rd=1, Rn=0, #4) -> next edge: valid_id=1, regw=1, imm_sel=1, a_id=0, b_id=4, rd_id=1.
//  regw_wb=1, rd_wb=3, result_wb=0xDEADBEEF, same cycle as instr reading Rn=3 -> a_id=0xDEADBEEF (bypass).
//  0x64012000 -> memr=1, regw=1, memw=0. 0x60012000 -> memw=1, regw=0. 0x80FFFFFE -> branch=1, cond=00, imm_id=0xFFFFFFF8.
//  stall_i=1 for 2 cycles with new instrs -> outputs unchanged. flush_i+stall_i together -> bubble (valid_id=0).
//  ID_HAZARD_DETECT_EN: 0x64012000 then instr with Rn=2 -> hazard_stall_o=1 one cycle, one bubble, then instr with a_id = loaded value.
//  Reset asserted mid-stream, asynchronously between edges -> all outputs 0 immediately; regfile reads 0 afterwards.

Source files
------------

// File: rtl/id_pkg.sv
// Shared types and encoding constants for the instruction-decode stage:
// opcode enum, instruction field positions and the decoded control bundle.
package id_pkg;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_RSV = 2'b11
  } op_t;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 30;
  localparam int I_BIT    = 29;
  localparam int FUNCT_HI = 28;
  localparam int FUNCT_LO = 27;
  localparam int SL_BIT   = 26;
  localparam int RN_HI    = 19;
  localparam int RN_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 12;
  localparam int RM_HI    = 3;
  localparam int RM_LO    = 0;

  localparam logic [3:0] PC_REG = 4'hF;

  typedef struct packed {
    logic       regw;
    logic       flagw;
    logic       memw;
    logic       memr;
    logic       branch;
    logic       imm_sel;
    logic [1:0] alu_ctrl;
    logic [1:0] cond;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/id_stage_pipe_if.sv
// IF/ID inputs and ID/EX outputs of the decode stage bundled as one interface.
// master = upstream/downstream pipeline side, slave = the decode stage itself.
interface id_stage_pipe_if #(
  parameter int DATA_W = 32
);

  logic              valid_if;
  logic [31:0]       instr_if;
  logic [DATA_W-1:0] pc_if;

  logic              valid_id;
  logic [DATA_W-1:0] pc_id;
  logic [DATA_W-1:0] a_id;
  logic [DATA_W-1:0] b_id;
  logic [DATA_W-1:0] imm_id;
  logic [3:0]        rn_id;
  logic [3:0]        rm_id;
  logic [3:0]        rd_id;
  logic              regw_id;
  logic              flagw_id;
  logic              memw_id;
  logic              memr_id;
  logic              branch_id;
  logic              imm_sel_id;
  logic [1:0]        alu_ctrl_id;
  logic [1:0]        cond_id;

  modport master (
    output valid_if, instr_if, pc_if,
    input  valid_id, pc_id, a_id, b_id, imm_id, rn_id, rm_id, rd_id,
           regw_id, flagw_id, memw_id, memr_id, branch_id, imm_sel_id,
           alu_ctrl_id, cond_id
  );

  modport slave (
    input  valid_if, instr_if, pc_if,
    output valid_id, pc_id, a_id, b_id, imm_id, rn_id, rm_id, rd_id,
           regw_id, flagw_id, memw_id, memr_id, branch_id, imm_sel_id,
           alu_ctrl_id, cond_id
  );

endinterface

// File: rtl/id_regfile.sv
// Register file: one write port, two combinational read ports with write-through
// bypass. Index is the low $clog2(NREGS) bits; with 16 registers R15 is not writable.
module id_regfile
  import id_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [3:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [3:0]        raddr_a_i,
  input  logic [3:0]        raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  localparam int IDX_W = $clog2(NREGS);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [IDX_W-1:0]  widx;
  logic [IDX_W-1:0]  aidx;
  logic [IDX_W-1:0]  bidx;
  logic              wr_en;

  assign widx  = waddr_i[IDX_W-1:0];
  assign aidx  = raddr_a_i[IDX_W-1:0];
  assign bidx  = raddr_b_i[IDX_W-1:0];
  assign wr_en = we_i && !((NREGS == 16) && (waddr_i == PC_REG));

  // NOTE: every entry must read 0 after reset, so the array is cleared by the
  // async reset; this forces flops rather than a RAM macro, which is intended here.
  // NOTE: sequential state is written with <= so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[widx] <= wdata_i;
    end
  end

  assign rdata_a_o = (wr_en && (widx == aidx)) ? wdata_i : regs_q[aidx];
  assign rdata_b_o = (wr_en && (widx == bidx)) ? wdata_i : regs_q[bidx];

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: decoder, immediate extender, operand read and the
// ID/EX register. Optional load-use hazard detection under ID_HAZARD_DETECT_EN.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int NREGS          = 16,
  parameter int PC_READ_OFFSET = 8
) (
  input  logic              clk,
  input  logic              reset,
  id_stage_pipe_if.slave    bus,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              regw_wb,
  input  logic [3:0]        rd_wb,
  input  logic [DATA_W-1:0] result_wb,
  output logic              hazard_stall_o
);

  localparam logic [DATA_W-1:0] PC_OFF = DATA_W'(PC_READ_OFFSET);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
    logic [3:0]        rn;
    logic [3:0]        rm;
    logic [3:0]        rd;
    ctrl_t             ctrl;
  } idex_t;

  op_t               op;
  logic              i_bit;
  logic              sl_bit;
  logic [1:0]        funct;
  logic [3:0]        rn;
  logic [3:0]        rm;
  logic [3:0]        rd;
  ctrl_t             dec_ctrl;
  logic              dec_legal;
  logic [DATA_W-1:0] dec_imm;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic [DATA_W-1:0] a_val;
  logic [DATA_W-1:0] rm_val;
  logic              hazard;
  idex_t             idex_d;
  idex_t             idex_q;
  logic              unused_instr_bits;

  assign op     = op_t'(bus.instr_if[OP_HI:OP_LO]);
  assign i_bit  = bus.instr_if[I_BIT];
  assign sl_bit = bus.instr_if[SL_BIT];
  assign funct  = bus.instr_if[FUNCT_HI:FUNCT_LO];
  assign rn     = bus.instr_if[RN_HI:RN_LO];
  assign rm     = bus.instr_if[RM_HI:RM_LO];
  assign rd     = bus.instr_if[RD_HI:RD_LO];
  assign unused_instr_bits = ^bus.instr_if[25:24];

  // NOTE: defaults are assigned first so every path drives every variable and
  // no latch can be inferred.
  always_comb begin
    dec_ctrl  = BUBBLE_CTRL;
    dec_legal = 1'b1;
    dec_imm   = {{(DATA_W-12){1'b0}}, bus.instr_if[11:0]};
    case (op)
      OP_DP: begin
        dec_ctrl.regw     = 1'b1;
        dec_ctrl.flagw    = sl_bit;
        dec_ctrl.alu_ctrl = funct;
        dec_ctrl.imm_sel  = i_bit;
      end
      OP_MEM: begin
        dec_ctrl.imm_sel = 1'b1;
        dec_ctrl.memr    = sl_bit;
        dec_ctrl.regw    = sl_bit;
        dec_ctrl.memw    = !sl_bit;
      end
      OP_BR: begin
        dec_ctrl.branch  = 1'b1;
        dec_ctrl.cond    = funct;
        dec_ctrl.imm_sel = 1'b1;
        dec_imm = {{(DATA_W-26){bus.instr_if[23]}}, bus.instr_if[23:0], 2'b00};
      end
      default: dec_legal = 1'b0;
    endcase
  end

  id_regfile #(
    .DATA_W(DATA_W),
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we_i     (regw_wb),
    .waddr_i  (rd_wb),
    .wdata_i  (result_wb),
    .raddr_a_i(rn),
    .raddr_b_i(rm),
    .rdata_a_o(rf_a),
    .rdata_b_o(rf_b)
  );

  // R15 is not storage: it reads as the instruction's PC plus the pipeline offset.
  assign a_val  = ((NREGS == 16) && (rn == PC_REG)) ? bus.pc_if + PC_OFF : rf_a;
  assign rm_val = ((NREGS == 16) && (rm == PC_REG)) ? bus.pc_if + PC_OFF : rf_b;

`ifdef ID_HAZARD_DETECT_EN
  assign hazard = !reset && idex_q.valid && idex_q.ctrl.memr && (idex_q.rd != PC_REG) &&
                  bus.valid_if && ((idex_q.rd == rn) || (!i_bit && (idex_q.rd == rm)));
`else
  assign hazard = 1'b0;
`endif
  assign hazard_stall_o = hazard;

  // The B operand is the second ALU input: immediate when imm_sel, else Rm.
  always_comb begin
    idex_d = idex_q;
    if (flush_i) begin
      idex_d = '0;
    end else if (stall_i) begin
      idex_d = idex_q;
    end else if (hazard || !bus.valid_if || !dec_legal) begin
      idex_d = '0;
    end else begin
      idex_d.valid = 1'b1;
      idex_d.pc    = bus.pc_if;
      idex_d.a     = a_val;
      idex_d.b     = dec_ctrl.imm_sel ? dec_imm : rm_val;
      idex_d.imm   = dec_imm;
      idex_d.rn    = rn;
      idex_d.rm    = rm;
      idex_d.rd    = rd;
      idex_d.ctrl  = dec_ctrl;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) idex_q <= '0;
    else       idex_q <= idex_d;
  end

  assign bus.valid_id    = idex_q.valid;
  assign bus.pc_id       = idex_q.pc;
  assign bus.a_id        = idex_q.a;
  assign bus.b_id        = idex_q.b;
  assign bus.imm_id      = idex_q.imm;
  assign bus.rn_id       = idex_q.rn;
  assign bus.rm_id       = idex_q.rm;
  assign bus.rd_id       = idex_q.rd;
  assign bus.regw_id     = idex_q.ctrl.regw;
  assign bus.flagw_id    = idex_q.ctrl.flagw;
  assign bus.memw_id     = idex_q.ctrl.memw;
  assign bus.memr_id     = idex_q.ctrl.memr;
  assign bus.branch_id   = idex_q.ctrl.branch;
  assign bus.imm_sel_id  = idex_q.ctrl.imm_sel;
  assign bus.alu_ctrl_id = idex_q.ctrl.alu_ctrl;
  assign bus.cond_id     = idex_q.ctrl.cond;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: behavioural model plus per-cycle compare,
// and directed vectors with literal expectations. Honours ID_HAZARD_DETECT_EN.
module tb_id_stage_pipe;

  localparam int DATA_W = 32;
  localparam int NREGS  = 16;
  localparam int PC_OFF = 8;
`ifdef ID_HAZARD_DETECT_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        regw_wb = 1'b0;
  logic [3:0]  rd_wb = 4'h0;
  logic [31:0] result_wb = 32'h0;
  logic        hazard_stall_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_stage_pipe_if #(.DATA_W(DATA_W)) bus ();

  id_stage_pipe #(
    .DATA_W        (DATA_W),
    .NREGS         (NREGS),
    .PC_READ_OFFSET(PC_OFF)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .regw_wb       (regw_wb),
    .rd_wb         (rd_wb),
    .result_wb     (result_wb),
    .hazard_stall_o(hazard_stall_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, a, b, imm;
    logic [3:0]  rn, rm, rd;
    logic        regw, flagw, memw, memr, branch, imm_sel;
    logic [1:0]  alu, cond;
    logic        known;
  } ent_t;

  logic [31:0] m_rf [16];
  ent_t        exp_e;

  function automatic logic [31:0] m_read(input logic [3:0] idx, input logic [31:0] pc);
    if (idx == 4'd15) return pc + PC_OFF;
    if (regw_wb && rd_wb == idx) return result_wb;
    return m_rf[idx];
  endfunction

  function automatic ent_t m_bubble();
    ent_t e;
    e = '0;
    e.known = 1'b1;
    return e;
  endfunction

  function automatic ent_t m_decode(input logic [31:0] ins, input logic [31:0] pc);
    ent_t              e;
    logic [31:0]       reg_b;
    logic signed [31:0] s;
    e = '0;
    e.pc = pc;
    e.rn = ins[19:16];
    e.rm = ins[3:0];
    e.rd = ins[15:12];
    e.a  = m_read(e.rn, pc);
    reg_b = m_read(e.rm, pc);
    e.imm = ins & 32'h0000_0FFF;
    case (ins[31:30])
      2'd0: begin
        e.valid = 1; e.regw = 1; e.flagw = ins[26]; e.alu = ins[28:27]; e.imm_sel = ins[29];
      end
      2'd1: begin
        e.valid = 1; e.imm_sel = 1;
        if (ins[26]) begin e.memr = 1; e.regw = 1; end
        else e.memw = 1;
      end
      2'd2: begin
        e.valid = 1; e.branch = 1; e.cond = ins[28:27]; e.imm_sel = 1;
        s = $signed(ins << 8) >>> 6;
        e.imm = s;
      end
      default: begin
        e = '0;
        return e;
      end
    endcase
    e.b = e.imm_sel ? e.imm : reg_b;
    e.known = 1'b1;
    return e;
  endfunction

  // One compare process: hazard just before each edge, registers just after it.
  initial begin : compare
    ent_t nxt;
    logic exp_haz;
    forever begin
      @(negedge clk);
      #4;
      if (reset) begin
        for (int i = 0; i < 16; i++) m_rf[i] = '0;
        exp_e = m_bubble();
        continue;
      end
      exp_haz = HAZ && exp_e.valid && exp_e.memr && exp_e.rd != 4'd15 && bus.valid_if &&
                (exp_e.rd == bus.instr_if[19:16] ||
                 (!bus.instr_if[29] && exp_e.rd == bus.instr_if[3:0]));
      check("hazard_stall_o", 32'(hazard_stall_o), 32'(exp_haz));
      if (flush_i)                          nxt = m_bubble();
      else if (stall_i)                     nxt = exp_e;
      else if (exp_haz || !bus.valid_if)    nxt = m_bubble();
      else                                  nxt = m_decode(bus.instr_if, bus.pc_if);
      @(posedge clk);
      #1;
      if (reset) continue;
      exp_e = nxt;
      if (regw_wb && rd_wb != 4'd15) m_rf[rd_wb] = result_wb;
      check("valid_id",    32'(bus.valid_id),    32'(exp_e.valid));
      check("regw_id",     32'(bus.regw_id),     32'(exp_e.regw));
      check("flagw_id",    32'(bus.flagw_id),    32'(exp_e.flagw));
      check("memw_id",     32'(bus.memw_id),     32'(exp_e.memw));
      check("memr_id",     32'(bus.memr_id),     32'(exp_e.memr));
      check("branch_id",   32'(bus.branch_id),   32'(exp_e.branch));
      check("imm_sel_id",  32'(bus.imm_sel_id),  32'(exp_e.imm_sel));
      check("alu_ctrl_id", 32'(bus.alu_ctrl_id), 32'(exp_e.alu));
      check("cond_id",     32'(bus.cond_id),     32'(exp_e.cond));
      if (exp_e.known) begin
        check("pc_id",  bus.pc_id,  exp_e.pc);
        check("a_id",   bus.a_id,   exp_e.a);
        check("b_id",   bus.b_id,   exp_e.b);
        check("imm_id", bus.imm_id, exp_e.imm);
        check("rn_id",  32'(bus.rn_id), 32'(exp_e.rn));
        check("rm_id",  32'(bus.rm_id), 32'(exp_e.rm));
        check("rd_id",  32'(bus.rd_id), 32'(exp_e.rd));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [31:0] ins, input logic [31:0] pc);
    bus.valid_if = 1'b1;
    bus.instr_if = ins;
    bus.pc_if    = pc;
  endtask

  task automatic wb(input logic en, input logic [3:0] rd, input logic [31:0] data);
    regw_wb   = en;
    rd_wb     = rd;
    result_wb = data;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " valid_id"},  32'(bus.valid_id), 0);
    check({tag, " pc_id"},     bus.pc_id, 0);
    check({tag, " a_id"},      bus.a_id, 0);
    check({tag, " b_id"},      bus.b_id, 0);
    check({tag, " imm_id"},    bus.imm_id, 0);
    check({tag, " rd_id"},     32'(bus.rd_id), 0);
    check({tag, " regw_id"},   32'(bus.regw_id), 0);
    check({tag, " memr_id"},   32'(bus.memr_id), 0);
    check({tag, " hazard"},    32'(hazard_stall_o), 0);
  endtask

  initial begin : driver
    bus.valid_if = 1'b0;
    bus.instr_if = 32'h0;
    bus.pc_if    = 32'h0;
    #2;
    check_all_zero("reset");
    tick();
    tick();
    reset = 1'b0;

    // ADD immediate after reset
    set_instr(32'h2000_1004, 32'h0);
    tick();
    check("add valid", 32'(bus.valid_id), 1);
    check("add regw", 32'(bus.regw_id), 1);
    check("add imm_sel", 32'(bus.imm_sel_id), 1);
    check("add a", bus.a_id, 0);
    check("add b", bus.b_id, 4);
    check("add rd", 32'(bus.rd_id), 1);

    // write-back bypass into Rn
    set_instr(32'h0003_4005, 32'h4);
    wb(1'b1, 4'd3, 32'hDEAD_BEEF);
    tick();
    check("bypass a", bus.a_id, 32'hDEAD_BEEF);
    check("bypass b", bus.b_id, 0);

    // stored value on Rn, bypass on Rm
    set_instr(32'h0003_4005, 32'h8);
    wb(1'b1, 4'd5, 32'h0000_0011);
    tick();
    check("stored a", bus.a_id, 32'hDEAD_BEEF);
    check("bypass rm b", bus.b_id, 32'h11);

    // R15 reads PC+8; a concurrent write to R15 is ignored
    set_instr(32'h000F_1003, 32'h100);
    wb(1'b1, 4'd15, 32'h55);
    tick();
    check("r15 a", bus.a_id, 32'h108);
    check("r15 rm b", bus.b_id, 32'hDEAD_BEEF);
    wb(1'b0, 4'd0, 32'h0);

    // DP register form with S and funct=3
    set_instr(32'h1C02_3006, 32'h10C);
    tick();
    check("dp flagw", 32'(bus.flagw_id), 1);
    check("dp alu", 32'(bus.alu_ctrl_id), 3);
    check("dp imm_sel", 32'(bus.imm_sel_id), 0);

    // load, then a consumer of its destination
    set_instr(32'h6401_2000, 32'h110);
    tick();
    check("ldr memr", 32'(bus.memr_id), 1);
    check("ldr regw", 32'(bus.regw_id), 1);
    check("ldr memw", 32'(bus.memw_id), 0);
    set_instr(32'h0002_5000, 32'h114);
    #1;
    check("load-use hazard", 32'(hazard_stall_o), 32'(HAZ));
    tick();
    check("load-use valid", 32'(bus.valid_id), 32'(!HAZ));
    wb(1'b1, 4'd2, 32'hCAFE_0002);
    tick();
    check("load-use a", bus.a_id, 32'hCAFE_0002);
    check("load-use valid2", 32'(bus.valid_id), 1);
    wb(1'b0, 4'd0, 32'h0);

    // store
    set_instr(32'h6001_2000, 32'h118);
    tick();
    check("str memw", 32'(bus.memw_id), 1);
    check("str regw", 32'(bus.regw_id), 0);

    // branches: negative and positive offsets
    set_instr(32'h80FF_FFFE, 32'h11C);
    tick();
    check("br branch", 32'(bus.branch_id), 1);
    check("br cond", 32'(bus.cond_id), 0);
    check("br imm", bus.imm_id, 32'hFFFF_FFF8);
    set_instr(32'h9000_0010, 32'h120);
    tick();
    check("br2 cond", 32'(bus.cond_id), 2);
    check("br2 imm", bus.imm_id, 32'h40);

    // reserved op and invalid input both give a bubble
    set_instr(32'hC000_0000, 32'h124);
    tick();
    check("rsv valid", 32'(bus.valid_id), 0);
    check("rsv regw", 32'(bus.regw_id), 0);
    bus.valid_if = 1'b0;
    tick();
    check("nvalid valid", 32'(bus.valid_id), 0);

    // stall holds for two cycles, then flush beats stall
    set_instr(32'h2000_1004, 32'h200);
    tick();
    stall_i = 1'b1;
    set_instr(32'h80FF_FFFE, 32'h300);
    tick();
    check("stall1 pc", bus.pc_id, 32'h200);
    check("stall1 b", bus.b_id, 4);
    set_instr(32'h6401_2000, 32'h304);
    tick();
    check("stall2 pc", bus.pc_id, 32'h200);
    check("stall2 valid", 32'(bus.valid_id), 1);
    flush_i = 1'b1;
    tick();
    check("flush valid", 32'(bus.valid_id), 0);
    check("flush pc", bus.pc_id, 0);
    stall_i = 1'b0;
    flush_i = 1'b0;

    // asynchronous reset between edges
    set_instr(32'h0003_4005, 32'h400);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async reset");
    tick();
    reset = 1'b0;
    set_instr(32'h0003_4005, 32'h404);
    tick();
    check("post-reset valid", 32'(bus.valid_id), 1);
    check("post-reset a", bus.a_id, 0);
    check("post-reset b", bus.b_id, 0);

    bus.valid_if = 1'b0;
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
